// File: rtl/uart_baud_gen.sv
// UART baud generator: fractional divisor register, enable control,
// and oversample (rx_tick) / bit-rate (tx_tick) tick outputs.
module uart_baud_gen #(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4,
  parameter int unsigned OVERSAMPLE = 16,
  parameter logic [31:0] DIV_ADDR   = 32'hC,
  parameter logic [31:0] CTRL_ADDR  = 32'h10,
  parameter int unsigned RESET_DIV  = 54,
  parameter int unsigned RESET_FRAC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  output logic [31:0] rdata,
  output logic        rx_tick,
  output logic        tx_tick
);

  localparam int unsigned CW = DIV_W + 1;
  localparam int unsigned OW = $clog2(OVERSAMPLE);

  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  div_n;
  logic [DIV_W-1:0]  div_w;
  logic [FRAC_W-1:0] frac;
  logic [FRAC_W-1:0] frac_n;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] acc_sum;
  logic              carry;
  logic              en;
  logic              en_n;
  logic [CW-1:0]     cnt;
  logic [OW-1:0]     os;
  logic              div_wr;
  logic              ctrl_wr;
  logic              unused_wdata;

  assign unused_wdata = ^wdata[31:DIV_W+FRAC_W];

  assign div_wr  = wr_en && (addr == DIV_ADDR);
  assign ctrl_wr = wr_en && (addr == CTRL_ADDR);

  assign div_w = (wdata[DIV_W-1:0] < DIV_W'(2))
               ? DIV_W'(2) : wdata[DIV_W-1:0];

  assign div_n  = div_wr  ? div_w : div;
  assign frac_n = div_wr  ? wdata[DIV_W+FRAC_W-1:DIV_W] : frac;
  assign en_n   = ctrl_wr ? wdata[0] : en;

  assign {carry, acc_sum} = {1'b0, acc} + {1'b0, frac};

  assign rx_tick = en && (cnt == '0);
  assign tx_tick = rx_tick && (os == OW'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div  <= DIV_W'(RESET_DIV);
      frac <= FRAC_W'(RESET_FRAC);
      en   <= 1'b1;
      cnt  <= CW'(RESET_DIV - 1);
      acc  <= '0;
      os   <= '0;
    end else begin
      div  <= div_n;
      frac <= frac_n;
      en   <= en_n;
      // Idle (or about to idle): park the counter one period out.
      if (!en || !en_n) begin
        cnt <= {1'b0, div_n} - CW'(1);
        acc <= '0;
        os  <= '0;
      end else if (rx_tick) begin
        cnt <= {1'b0, div} - CW'(1) + CW'(carry);
        acc <= acc_sum;
        os  <= os + OW'(1);
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (addr == DIV_ADDR):  rdata[DIV_W+FRAC_W-1:0] = {frac, div};
      (addr == CTRL_ADDR): rdata[0] = en;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: tick schedule model with scoreboard queue,
// plus register readback checks.
module tb_uart_baud_gen;

  localparam int OSR   = 16;
  localparam int FRW   = 4;
  localparam int RDIV  = 54;
  localparam int RFRAC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr_en;
  logic [31:0] rdata;
  logic        rx_tick;
  logic        tx_tick;

  uart_baud_gen dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wdata   (wdata),
    .wr_en   (wr_en),
    .rdata   (rdata),
    .rx_tick (rx_tick),
    .tx_tick (tx_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit tx;
  } tick_t;

  tick_t       tq[$];
  logic [31:0] rd_q[$];
  bit          rd_v = 1'b0;

  int cyc = 0;
  int m_div = 0;
  int m_frac = 0;
  int m_acc = 0;
  int m_next = 0;
  int m_k = 0;
  bit m_en = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void schedule(int t);
    tick_t e;
    e.cyc = t;
    e.tx = (m_k % OSR) == OSR - 1;
    m_next = t;
    tq.push_back(e);
  endfunction

  function automatic logic [31:0] exp_div();
    logic [31:0] v;
    v = '0;
    v[15:0] = m_div[15:0];
    v[19:16] = m_frac[3:0];
    return v;
  endfunction

  function automatic logic [31:0] exp_ctrl();
    logic [31:0] v;
    v = '0;
    v[0] = m_en;
    return v;
  endfunction

  // Reference: each tick schedules the next one div (+1 on carry) later
  initial begin
    int s;
    int c;
    forever begin
      @(posedge clk);
      if (m_en && cyc == m_next) begin
        s = m_acc + m_frac;
        c = (s >= 2**FRW) ? 1 : 0;
        m_acc = s % (2**FRW);
        m_k++;
        schedule(cyc + m_div + c);
      end
      if (reset) begin
        tq.delete();
        m_div = RDIV;
        m_frac = RFRAC;
        m_en = 1'b1;
        m_acc = 0;
        m_k = 0;
        schedule(cyc + RDIV);
      end else if (wr_en && addr == 32'hC) begin
        m_div = (wdata[15:0] < 2) ? 2 : int'(wdata[15:0]);
        m_frac = int'(wdata[19:16]);
      end else if (wr_en && addr == 32'h10) begin
        if (!wdata[0]) begin
          tq.delete();
          m_en = 1'b0;
        end else if (!m_en) begin
          m_en = 1'b1;
          m_acc = 0;
          m_k = 0;
          schedule(cyc + m_div);
        end
      end
      cyc++;
    end
  end

  initial begin
    tick_t e;
    logic [31:0] x;
    forever begin
      @(negedge clk);
      if (rd_v) begin
        x = rd_q.pop_front();
        n_chk++;
        if (rdata !== x)
          $display("FAIL rdata addr=%h got %h expected %h", addr, rdata, x);
        else
          n_pass++;
      end
      while (tq.size() > 0 && tq[0].cyc < cyc) begin
        n_chk++;
        $display("FAIL missed_tick at cycle %0d got none expected rx_tick",
                 tq[0].cyc);
        void'(tq.pop_front());
      end
      if (rx_tick === 1'b1) begin
        n_chk++;
        if (tq.size() == 0 || tq[0].cyc != cyc) begin
          $display("FAIL extra_tick at cycle %0d got rx_tick expected none",
                   cyc);
        end else begin
          e = tq.pop_front();
          if (tx_tick !== e.tx)
            $display("FAIL tx_tick at cycle %0d got %b expected %b",
                     cyc, tx_tick, e.tx);
          else
            n_pass++;
        end
      end else if (tx_tick !== 1'b0) begin
        n_chk++;
        $display("FAIL lone_tx at cycle %0d got tx=%b expected 0",
                 cyc, tx_tick);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    addr = a;
    wdata = d;
    wr_en = 1'b1;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic rd(logic [31:0] a, logic [31:0] x);
    addr = a;
    rd_q.push_back(x);
    rd_v = 1'b1;
    step(1);
    rd_v = 1'b0;
  endtask

  initial begin
    int op;
    logic [31:0] d;
    logic [31:0] ua;
    reset = 1'b1;
    addr = '0;
    wdata = '0;
    wr_en = 1'b0;
    step(3);
    reset = 1'b0;

    rd(32'hC, 32'h0004_0036);
    rd(32'h10, 32'h1);
    rd(32'h8, 32'h0);
    step(4 * 54 + 10);

    wr(32'hC, 32'h0000_000A);
    rd(32'hC, 32'h0000_000A);
    step(340);

    wr(32'hC, 32'h0000_0000);
    rd(32'hC, 32'h0000_0002);
    step(40);
    wr(32'hC, 32'h0000_0001);
    rd(32'hC, 32'h0000_0002);
    step(20);

    wr(32'hC, 32'h0008_000A);
    rd(32'hC, 32'h0008_000A);
    step(400);

    step($urandom_range(1, 9));
    wr(32'h10, 32'h0);
    rd(32'h10, 32'h0);
    step(200);
    wr(32'h10, 32'h1);
    rd(32'h10, 32'h1);
    step(10 * 17 + 20);

    wr(32'h10, 32'h0);
    wr(32'hC, 32'h0000_FFFF);
    rd(32'hC, 32'h0000_FFFF);
    wr(32'h10, 32'h1);
    step(65540);
    wr(32'h10, 32'h0);
    wr(32'hC, 32'h0003_0007);
    wr(32'h10, 32'h1);
    step(30);

    step(m_next - cyc);
    wr(32'hC, 32'h0000_0004);
    step(40);

    step($urandom_range(5, 40));
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    rd(32'hC, 32'h0004_0036);
    step(4 * 54 + 10);

    d = $urandom;
    wr(32'h8, d);
    rd(32'h8, 32'h0);
    rd(32'hC, 32'h0004_0036);
    rd(32'h10, 32'h1);

    for (int i = 0; i < 12; i++) begin
      op = $urandom_range(0, 9);
      if (op < 5) begin
        d = '0;
        d[15:0] = 16'($urandom_range(0, 25));
        d[19:16] = 4'($urandom);
        d[31:20] = 12'($urandom);
        wr(32'hC, d);
      end else if (op < 8) begin
        wr(32'h10, {31'($urandom), ~m_en});
      end else if (op < 9) begin
        ua = 32'h4 * 32'($urandom_range(0, 2));
        wr(ua, $urandom);
      end else begin
        reset = 1'b1;
        step(1);
        reset = 1'b0;
      end
      rd(32'hC, exp_div());
      rd(32'h10, exp_ctrl());
      step($urandom_range(5, 80));
    end

    wr(32'h10, 32'h1);
    step(120);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
